cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Run/step/breakpoint sequencer for the single-cycle CPU core. Drives the core's global_en so that
//  the core executes free-running, a fixed number of instructions, or until a halt or breakpoint.
//  Sits between the debug host command interface and the CPU top; observes the fetch PC and instruction.
// PARAMETERS
//  NUM_BP     2             number of PC breakpoint slots (1..8)
//  CNT_W      32            width of step and instruction counters
//  HALT_INST  32'h8000_0000 encoding that stops the core after it commits
// PORTS
//  clk          in   1      clock
//  rst          in   1      reset, synchronous, active-high
//  cmd_valid    in   1      host command strobe
//  cmd_ready    out  1      always 1; command accepted when cmd_valid=1
//  cmd_op       in   3      0 NOP, 1 RUN, 2 STEP, 3 PAUSE, 4 CLEAR, 5 SET_BP, 6 DEL_BP
//  cmd_arg      in   32     STEP: count (CNT_W LSBs); SET_BP: breakpoint PC
//  cmd_bp_idx   in   3      breakpoint slot for SET_BP/DEL_BP (out-of-range index: command ignored)
//  fetch_pc     in   32     core PC of the instruction presented this cycle
//  fetch_inst   in   32     core instruction presented this cycle
//  global_en    out  1      core execute enable (combinational from state + fetch inputs)
//  ctrl_state   out  2      0 IDLE, 1 RUN, 2 STEP, 3 DONE
//  stop_reason  out  3      0 NONE, 1 PAUSE, 2 STEP_DONE, 3 BREAKPOINT, 4 HALT
//  inst_cnt     out  CNT_W  instructions executed (cycles with global_en=1), saturating
//  step_left    out  CNT_W  remaining step count
// BEHAVIOUR
//  Reset: state IDLE, global_en=0, stop_reason NONE, inst_cnt=0, step_left=0, all bp slots invalid, skip_bp=0.
//  bp_hit = any valid slot with bp_pc==fetch_pc, gated by !skip_bp.
//  global_en = (RUN|STEP) & !bp_hit & !(cmd accepted with op PAUSE or CLEAR). It is 0 in IDLE and DONE.
//  IDLE: RUN goes to RUN. STEP goes to STEP with step_left=max(arg,1).
//    Both set skip_bp=1 and set stop_reason to NONE. PAUSE is a no-op.
//  RUN/STEP: on each cycle with global_en=1, inst_cnt+1 (saturating at all-ones) and skip_bp cleared.
//    STEP also decrements step_left.
//  Stop priority in RUN/STEP, evaluated each cycle:
//    CLEAR > PAUSE > HALT > BREAKPOINT > STEP_DONE.
//    PAUSE cmd: go to IDLE, reason PAUSE; the instruction is not executed.
//    fetch_inst==HALT_INST and global_en=1: the halt executes this cycle; next state DONE, reason HALT.
//    bp_hit: go to IDLE, reason BREAKPOINT; the instruction is not executed.
//      A following RUN/STEP executes it (skip_bp).
//    STEP with step_left==1 and global_en=1: go to IDLE, reason STEP_DONE, step_left=0.
//  RUN/STEP commands received in RUN, STEP or DONE are ignored.
//  DONE is left only via CLEAR or rst; the core must be reset before rerunning.
//  CLEAR, from any state: go to IDLE, reason NONE, inst_cnt=0, step_left=0. Breakpoints are kept.
//  SET_BP/DEL_BP are legal in any state and take effect on bp_hit from the next cycle.
//  Reset mid-run: the controller returns to reset values regardless of in-flight commands.
// STRUCTURE
//  Package cpu_ctrl_pkg holds the cmd_op, ctrl_state and stop_reason encodings and the HALT_INST default.
//  Sub-module cpu_bp_match holds the NUM_BP-slot valid/PC register file and the parallel compare.
//    Its output is a single hit bit.
//  Top holds the FSM, skip_bp flag, step/inst counters and global_en logic.
// TESTING
//  RUN, fetch_inst!=HALT for 10 cycles then ==HALT_INST -> global_en=1 on 11 cycles,
//    then DONE, reason 4, inst_cnt=11.
//  STEP arg=3 from IDLE -> global_en high exactly 3 cycles, then IDLE, reason 2, step_left=0, inst_cnt=3;
//    STEP arg=0 -> exactly 1 cycle.
//  SET_BP slot0=0x0000_0010, RUN, fetch_pc reaches 0x10 -> global_en=0 that cycle, IDLE, reason 3;
//    RUN again -> 0x10 executes, no re-stop.
//  PAUSE during RUN -> global_en=0 in the accepting cycle, IDLE, reason 1, inst_cnt frozen.
//  PAUSE and HALT_INST in the same cycle -> PAUSE wins, halt not executed;
//    CLEAR in DONE -> IDLE, inst_cnt=0, slot0 still valid.
//  rst asserted mid-STEP with step_left=5 -> next cycle IDLE, global_en=0, all counters 0, bps invalid.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU run/step/breakpoint sequencer.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_RUN    = 3'd1,
        OP_STEP   = 3'd2,
        OP_PAUSE  = 3'd3,
        OP_CLEAR  = 3'd4,
        OP_SET_BP = 3'd5,
        OP_DEL_BP = 3'd6
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } ctrl_state_e;

    typedef enum logic [2:0] {
        SR_NONE       = 3'd0,
        SR_PAUSE      = 3'd1,
        SR_STEP_DONE  = 3'd2,
        SR_BREAKPOINT = 3'd3,
        SR_HALT       = 3'd4
    } stop_reason_e;

    localparam logic [31:0] HALT_INST_DEF = 32'h8000_0000;

endpackage

// File: rtl/cpu_bp_match.sv
// PC breakpoint slots with a parallel compare against the fetch PC; one hit bit out.
module cpu_bp_match #(
    parameter int NUM_BP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_en,
    input  logic        del_en,
    input  logic [2:0]  idx,
    input  logic [31:0] set_pc,
    input  logic [31:0] fetch_pc,
    output logic        hit
);

    logic [NUM_BP-1:0] valid_q, valid_d;
    logic [31:0]       pc_q [NUM_BP];
    logic [31:0]       pc_d [NUM_BP];

    // Indices at or above NUM_BP never match a slot, so such commands fall through.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        for (int i = 0; i < NUM_BP; i++) begin
            if (idx == 3'(i)) begin
                if (set_en) begin
                    valid_d[i] = 1'b1;
                    pc_d[i]    = set_pc;
                end else if (del_en) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_BP; i++) pc_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (valid_q[i] && (pc_q[i] == fetch_pc)) hit = 1'b1;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer driving the core's global_en.
//  state | meaning
//  IDLE  | core stopped, waiting for RUN/STEP
//  RUN   | free-running until pause, halt or breakpoint
//  STEP  | executing step_left more instructions
//  DONE  | halt committed; only CLEAR or rst leaves
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int          NUM_BP    = 2,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] HALT_INST = HALT_INST_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [31:0]      cmd_arg,
    input  logic [2:0]       cmd_bp_idx,
    input  logic [31:0]      fetch_pc,
    input  logic [31:0]      fetch_inst,
    output logic             global_en,
    output logic [1:0]       ctrl_state,
    output logic [2:0]       stop_reason,
    output logic [CNT_W-1:0] inst_cnt,
    output logic [CNT_W-1:0] step_left
);

    ctrl_state_e      state_q, state_d;
    stop_reason_e     reason_q, reason_d;
    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
    logic [CNT_W-1:0] step_left_q, step_left_d;
    logic             skip_bp_q, skip_bp_d;
    logic             bp_raw, bp_hit, active;
    logic             op_run, op_step, op_pause, op_clear;
    logic [CNT_W-1:0] step_arg;

    assign cmd_ready = 1'b1;
    assign op_run    = cmd_valid && (cmd_op == OP_RUN);
    assign op_step   = cmd_valid && (cmd_op == OP_STEP);
    assign op_pause  = cmd_valid && (cmd_op == OP_PAUSE);
    assign op_clear  = cmd_valid && (cmd_op == OP_CLEAR);
    assign step_arg  = cmd_arg[CNT_W-1:0];

    cpu_bp_match #(.NUM_BP(NUM_BP)) u_bp (
        .clk      (clk),
        .rst      (rst),
        .set_en   (cmd_valid && (cmd_op == OP_SET_BP)),
        .del_en   (cmd_valid && (cmd_op == OP_DEL_BP)),
        .idx      (cmd_bp_idx),
        .set_pc   (cmd_arg),
        .fetch_pc (fetch_pc),
        .hit      (bp_raw)
    );

    // skip_bp lets the instruction parked on a breakpoint execute on resume.
    assign bp_hit    = bp_raw && !skip_bp_q;
    assign active    = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign global_en = active && !bp_hit && !op_pause && !op_clear;

    always_comb begin
        state_d     = state_q;
        reason_d    = reason_q;
        inst_cnt_d  = inst_cnt_q;
        step_left_d = step_left_q;
        skip_bp_d   = skip_bp_q;

        if (global_en) begin
            inst_cnt_d = (inst_cnt_q == '1) ? inst_cnt_q : inst_cnt_q + CNT_W'(1);
            skip_bp_d  = 1'b0;
            if (state_q == ST_STEP) step_left_d = step_left_q - CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (op_run) begin
                    state_d   = ST_RUN;
                    reason_d  = SR_NONE;
                    skip_bp_d = 1'b1;
                end else if (op_step) begin
                    state_d     = ST_STEP;
                    reason_d    = SR_NONE;
                    skip_bp_d   = 1'b1;
                    step_left_d = (step_arg == '0) ? CNT_W'(1) : step_arg;
                end
            end
            ST_RUN, ST_STEP: begin
                if (op_pause) begin
                    state_d  = ST_IDLE;
                    reason_d = SR_PAUSE;
                end else if (global_en && (fetch_inst == HALT_INST)) begin
                    state_d  = ST_DONE;
                    reason_d = SR_HALT;
                end else if (bp_hit) begin
                    state_d  = ST_IDLE;
                    reason_d = SR_BREAKPOINT;
                end else if ((state_q == ST_STEP) && global_en && (step_left_q == CNT_W'(1))) begin
                    state_d     = ST_IDLE;
                    reason_d    = SR_STEP_DONE;
                    step_left_d = '0;
                end
            end
            default: ;
        endcase

        if (op_clear) begin
            state_d     = ST_IDLE;
            reason_d    = SR_NONE;
            inst_cnt_d  = '0;
            step_left_d = '0;
            skip_bp_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            reason_q    <= SR_NONE;
            inst_cnt_q  <= '0;
            step_left_q <= '0;
            skip_bp_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            reason_q    <= reason_d;
            inst_cnt_q  <= inst_cnt_d;
            step_left_q <= step_left_d;
            skip_bp_q   <= skip_bp_d;
        end
    end

    assign ctrl_state  = state_q;
    assign stop_reason = reason_q;
    assign inst_cnt    = inst_cnt_q;
    assign step_left   = step_left_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: run/halt, step, breakpoints, pause, clear, reset.
module tb_cpu_run_ctrl;

    localparam logic [31:0] HALT = 32'h8000_0000;
    localparam logic [31:0] NOPI = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic [2:0]  cmd_bp_idx;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        global_en;
    logic [1:0]  ctrl_state;
    logic [2:0]  stop_reason;
    logic [31:0] inst_cnt;
    logic [31:0] step_left;

    int total = 0;
    int bad   = 0;

    cpu_run_ctrl #(.NUM_BP(2), .CNT_W(32), .HALT_INST(HALT)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .cmd_bp_idx  (cmd_bp_idx),
        .fetch_pc    (fetch_pc),
        .fetch_inst  (fetch_inst),
        .global_en   (global_en),
        .ctrl_state  (ctrl_state),
        .stop_reason (stop_reason),
        .inst_cnt    (inst_cnt),
        .step_left   (step_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge: drive one cycle, sample global_en, land on next falling edge.
    task automatic cyc(input logic v, input logic [2:0] op, input logic [31:0] arg,
                       input logic [2:0] idx, input logic [31:0] pc, input logic [31:0] inst,
                       output logic en);
        cmd_valid  = v;
        cmd_op     = op;
        cmd_arg    = arg;
        cmd_bp_idx = idx;
        fetch_pc   = pc;
        fetch_inst = inst;
        #1;
        en = global_en;
        @(negedge clk);
    endtask

    task automatic chk_ctl(input string tag, input logic [1:0] st, input logic [2:0] rs,
                           input logic [31:0] ic);
        chk({tag, "_state"}, {30'd0, ctrl_state}, {30'd0, st});
        chk({tag, "_reason"}, {29'd0, stop_reason}, {29'd0, rs});
        chk({tag, "_inst_cnt"}, inst_cnt, ic);
    endtask

    initial begin
        logic en;
        int   n;

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = '0; cmd_bp_idx = '0;
        fetch_pc = 32'h100; fetch_inst = NOPI;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_en", {31'd0, global_en}, 32'd0);
        chk("reset_ready", {31'd0, cmd_ready}, 32'd1);
        chk_ctl("reset", 2'd0, 3'd0, 32'd0);
        chk("reset_step_left", step_left, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // RUN: 10 normal instructions then a halt
        cyc(1, 3'd1, 0, 0, 32'h100, NOPI, en);
        chk("run_cmd_en", {31'd0, en}, 32'd0);
        chk("run_state", {30'd0, ctrl_state}, 32'd1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 3'd0, 0, 0, 32'h100 + 32'(4 * i), NOPI, en);
            n += int'(en);
        end
        cyc(0, 3'd0, 0, 0, 32'h128, HALT, en);
        n += int'(en);
        chk("run_en_cycles", 32'(n), 32'd11);
        chk_ctl("run_halt", 2'd3, 3'd4, 32'd11);
        cyc(1, 3'd1, 0, 0, 32'h12c, NOPI, en);
        chk("done_run_en", {31'd0, en}, 32'd0);
        chk("done_run_ignored", {30'd0, ctrl_state}, 32'd3);
        cyc(1, 3'd4, 0, 0, 32'h12c, NOPI, en);
        chk_ctl("clear1", 2'd0, 3'd0, 32'd0);

        // STEP 3 then STEP 0
        cyc(1, 3'd2, 32'd3, 0, 32'h200, NOPI, en);
        chk("step3_state", {30'd0, ctrl_state}, 32'd2);
        chk("step3_left", step_left, 32'd3);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 3'd0, 0, 0, 32'h200 + 32'(4 * i), NOPI, en);
            n += int'(en);
        end
        chk("step3_en_cycles", 32'(n), 32'd3);
        chk_ctl("step3_end", 2'd0, 3'd2, 32'd3);
        chk("step3_left_end", step_left, 32'd0);
        cyc(1, 3'd2, 32'd0, 0, 32'h300, NOPI, en);
        chk("step0_left", step_left, 32'd1);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 3'd0, 0, 0, 32'h300 + 32'(4 * i), NOPI, en);
            n += int'(en);
        end
        chk("step0_en_cycles", 32'(n), 32'd1);
        chk_ctl("step0_end", 2'd0, 3'd2, 32'd4);
        cyc(1, 3'd4, 0, 0, 32'h0, NOPI, en);

        // Breakpoint at 0x10; slot 5 is out of range and must be ignored
        cyc(1, 3'd5, 32'h10, 3'd0, 32'h0, NOPI, en);
        cyc(1, 3'd5, 32'h20, 3'd5, 32'h0, NOPI, en);
        cyc(1, 3'd1, 0, 0, 32'h08, NOPI, en);
        cyc(0, 3'd0, 0, 0, 32'h0c, NOPI, en);
        chk("bp_pre_en", {31'd0, en}, 32'd1);
        cyc(0, 3'd0, 0, 0, 32'h20, NOPI, en);
        chk("bp_oor_idx_en", {31'd0, en}, 32'd1);
        cyc(0, 3'd0, 0, 0, 32'h10, NOPI, en);
        chk("bp_hit_en", {31'd0, en}, 32'd0);
        chk_ctl("bp_stop", 2'd0, 3'd3, 32'd2);
        cyc(1, 3'd1, 0, 0, 32'h10, NOPI, en);
        chk("bp_resume_reason", {29'd0, stop_reason}, 32'd0);
        cyc(0, 3'd0, 0, 0, 32'h10, NOPI, en);
        chk("bp_skip_en", {31'd0, en}, 32'd1);
        cyc(0, 3'd0, 0, 0, 32'h14, NOPI, en);
        chk("bp_after_en", {31'd0, en}, 32'd1);
        chk_ctl("bp_resumed", 2'd1, 3'd0, 32'd4);

        // PAUSE during RUN
        cyc(1, 3'd3, 0, 0, 32'h18, NOPI, en);
        chk("pause_en", {31'd0, en}, 32'd0);
        chk_ctl("pause", 2'd0, 3'd1, 32'd4);
        cyc(0, 3'd0, 0, 0, 32'h18, NOPI, en);
        chk("pause_frozen", inst_cnt, 32'd4);

        // Deleted slot does not stop; PAUSE beats HALT; HALT then CLEAR keeps slot 0
        cyc(1, 3'd5, 32'h40, 3'd1, 32'h38, NOPI, en);
        cyc(1, 3'd6, 32'h0, 3'd1, 32'h38, NOPI, en);
        cyc(1, 3'd1, 0, 0, 32'h3c, NOPI, en);
        cyc(0, 3'd0, 0, 0, 32'h3c, NOPI, en);
        cyc(0, 3'd0, 0, 0, 32'h40, NOPI, en);
        chk("del_bp_en", {31'd0, en}, 32'd1);
        cyc(1, 3'd3, 0, 0, 32'h44, HALT, en);
        chk("pause_halt_en", {31'd0, en}, 32'd0);
        chk_ctl("pause_halt", 2'd0, 3'd1, 32'd6);
        cyc(1, 3'd1, 0, 0, 32'h44, HALT, en);
        cyc(0, 3'd0, 0, 0, 32'h44, HALT, en);
        chk("halt2_en", {31'd0, en}, 32'd1);
        chk_ctl("halt2", 2'd3, 3'd4, 32'd7);
        cyc(1, 3'd4, 0, 0, 32'h48, NOPI, en);
        chk("clear_done_en", {31'd0, en}, 32'd0);
        chk_ctl("clear_done", 2'd0, 3'd0, 32'd0);
        cyc(1, 3'd1, 0, 0, 32'h2c, NOPI, en);
        cyc(0, 3'd0, 0, 0, 32'h30, NOPI, en);
        cyc(0, 3'd0, 0, 0, 32'h10, NOPI, en);
        chk("bp_kept_en", {31'd0, en}, 32'd0);
        chk_ctl("bp_kept", 2'd0, 3'd3, 32'd1);

        // Reset in the middle of a STEP with a RUN command in flight
        cyc(1, 3'd2, 32'd7, 0, 32'h100, NOPI, en);
        cyc(0, 3'd0, 0, 0, 32'h100, NOPI, en);
        cyc(0, 3'd0, 0, 0, 32'h104, NOPI, en);
        chk("mid_step_left", step_left, 32'd5);
        rst = 1'b1;
        cyc(1, 3'd1, 0, 0, 32'h108, NOPI, en);
        rst = 1'b0;
        #1;
        chk("rst_mid_en", {31'd0, global_en}, 32'd0);
        chk_ctl("rst_mid", 2'd0, 3'd0, 32'd0);
        chk("rst_mid_left", step_left, 32'd0);
        @(negedge clk);
        cyc(1, 3'd1, 0, 0, 32'h08, NOPI, en);
        cyc(0, 3'd0, 0, 0, 32'h0c, NOPI, en);
        cyc(0, 3'd0, 0, 0, 32'h10, NOPI, en);
        chk("rst_bp_cleared_en", {31'd0, en}, 32'd1);
        chk("rst_bp_cleared_state", {30'd0, ctrl_state}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
